seq_divider: RTL and testbench
==============================

// Module: seq_divider
// PURPOSE
//  Shared sequential unsigned divider serving the trip-statistics stages (average speed).
//  - Consumer presents a 26-bit dividend and a 26-bit divisor, then pulses start.
//  - Block runs a radix-2 restoring division and returns a saturated 16-bit quotient.
//  - Handshake: busy while working, one-cycle ready with the result.
//  - Sits between the average-speed stage (operand/result side) and the top-level start arbitration.
// PARAMETERS
//  WIDTH_IN   26  dividend/divisor width; also the iteration count
//  WIDTH_Q    16  result width; quotient saturates to 2^WIDTH_Q-1
// PORTS
//  clk        in   1        single system clock, rising edge
//  rst        in   1        asynchronous, active-low reset
//  en         in   1        clock enable; 0 freezes all state (outputs hold)
//  start      in   1        request; sampled only in IDLE
//  dividend   in   WIDTH_IN numerator, latched on accepted start
//  divisor    in   WIDTH_IN denominator, latched on accepted start
//  busy       out  1        1 while in CALC
//  ready      out  1        one-cycle pulse in DONE; result valid
//  result     out  WIDTH_Q  saturated quotient; held until the next DONE
//  overflow   out  1        quotient exceeded 2^WIDTH_Q-1 (result saturated); held with result
//  div_zero   out  1        divisor was 0; held with result
// BEHAVIOUR
//  - Reset (rst=0, async): state=IDLE; busy=0, ready=0, result=0, overflow=0, div_zero=0; iteration counter=0.
//    A reset mid-CALC aborts the operation; no ready is issued.
//  - en=0: no state, counter, remainder or output changes. ready stays high if frozen in DONE.
//  - FSM, active only when en=1:
//    - IDLE: start=1 -> CALC. Latch dividend into the quotient shift register, divisor into dreg, remainder=0, cnt=0.
//    - CALC: each cycle, rem' = {rem, q[MSB]}; q <<= 1.
//      If rem' >= dreg: rem' -= dreg and q[0]=1.
//      cnt++; after WIDTH_IN iterations (cnt==WIDTH_IN-1 processed) -> DONE.
//    - DONE: ready=1 for exactly one cycle -> IDLE.
//  - Output timing: result, overflow and div_zero are registered on the CALC->DONE edge, so they are valid in the ready cycle.
//  - Latency: start sampled at edge N -> busy=1 from N+1 to N+WIDTH_IN -> ready=1 in cycle N+WIDTH_IN+1.
//    Default latency is 27 cycles.
//  - Arithmetic (unsigned):
//    - Full quotient is WIDTH_IN bits, remainder WIDTH_IN+1 bits internally.
//    - If quotient[WIDTH_IN-1:WIDTH_Q] != 0: result=all ones, overflow=1.
//  - divisor==0:
//    - Same latency; restoring algorithm yields an all-ones quotient.
//    - Output is result=all ones, div_zero=1, overflow=1.
//  - start while busy or in DONE: ignored, not queued; operands not re-latched.
//    Consumers must wait for busy=0.
//  - start held high continuously: a new operation is accepted in the IDLE cycle after DONE (back-to-back period WIDTH_IN+2).
//  - Input changes during CALC have no effect; operands are latched.
//  - ready and busy are never high together.
// STRUCTURE
//  - Shared package bike_pkg: DIV_WIDTH_IN=26, DIV_WIDTH_Q=16, state typedef/localparams {S_IDLE, S_CALC, S_DONE}.
//  - Single module; no sub-module. The subtract/compare step stays inline (one combinational step per cycle).
//  - Counter width is $clog2(WIDTH_IN).
// TESTING
//  1. Reset/idle: rst=0 at any point -> busy=0, ready=0, result=0 within the same cycle (async).
//     rst released with no start -> outputs stay 0.
//  2. Basic: dividend=1000000, divisor=2750, start pulse -> busy for 26 cycles, ready in cycle 27, result=363, overflow=0.
//  3. Saturation: dividend=26'h3FFFFFF, divisor=1 -> result=16'hFFFF, overflow=1, div_zero=0.
//     Then dividend=65535, divisor=1 -> result=65535, overflow=0.
//  4. Divide by zero: dividend=12345, divisor=0 -> ready at same latency, result=16'hFFFF, div_zero=1, overflow=1.
//  5. Protocol: start re-pulsed mid-CALC with new operands -> ignored, first result unchanged.
//     en=0 for 5 cycles mid-CALC -> ready delayed by exactly 5.
//     rst pulse mid-CALC -> no ready issued.
//  6. Random: 1000 random operand pairs with start held high, compared against a reference model
//     (min(a/b, 65535); flags) -> all match, period 28 cycles.

Source files
------------

// File: rtl/bike_pkg.sv
// Shared definitions for the bike trip-statistics datapath.
// Holds the divider geometry and the divider FSM state encoding.
package bike_pkg;

  localparam int DIV_WIDTH_IN = 26;
  localparam int DIV_WIDTH_Q  = 16;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } div_state_t;

endpackage

// File: rtl/seq_divider.sv
// Shared sequential unsigned divider (radix-2 restoring).
// One quotient bit per enabled clock; the 16-bit result saturates and is
// held together with its overflow/div_zero flags until the next completion.
module seq_divider
  import bike_pkg::*;
#(
  parameter int WIDTH_IN = DIV_WIDTH_IN,
  parameter int WIDTH_Q  = DIV_WIDTH_Q
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic                start,
  input  logic [WIDTH_IN-1:0] dividend,
  input  logic [WIDTH_IN-1:0] divisor,
  output logic                busy,
  output logic                ready,
  output logic [WIDTH_Q-1:0]  result,
  output logic                overflow,
  output logic                div_zero
);

  localparam int              CNT_W    = $clog2(WIDTH_IN);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH_IN - 1);

  // Clamp a full-width quotient into the result width.
  function automatic logic [WIDTH_Q-1:0] sat_quot(input logic [WIDTH_IN-1:0] q);
    if (|q[WIDTH_IN-1:WIDTH_Q]) begin
      return '1;
    end
    return q[WIDTH_Q-1:0];
  endfunction

  // True when the full quotient does not fit in the result width.
  function automatic logic quot_ovf(input logic [WIDTH_IN-1:0] q);
    return |q[WIDTH_IN-1:WIDTH_Q];
  endfunction

  div_state_t          r_state;
  div_state_t          w_state_nx;
  logic                w_accept;
  logic                w_last;
  logic                w_busy;
  logic                w_ready;

  logic [CNT_W-1:0]    r_cnt;
  logic [WIDTH_IN-1:0] r_q;
  logic [WIDTH_IN-1:0] r_dreg;
  logic [WIDTH_IN:0]   r_rem;

  logic [WIDTH_Q-1:0]  r_result;
  logic                r_overflow;
  logic                r_div_zero;

  logic [WIDTH_IN:0]   w_rem_sh;
  logic                w_ge;
  logic [WIDTH_IN:0]   w_rem_nx;
  logic [WIDTH_IN-1:0] w_q_nx;

  // One restoring step: shift in the next dividend bit, trial-subtract.
  // The remainder's top bit is folded into the compare so an out-of-range
  // remainder can never skip its subtraction.
  assign w_rem_sh = {r_rem[WIDTH_IN-1:0], r_q[WIDTH_IN-1]};
  assign w_ge     = r_rem[WIDTH_IN] | (w_rem_sh >= {1'b0, r_dreg});
  assign w_rem_nx = w_ge ? (w_rem_sh - {1'b0, r_dreg}) : w_rem_sh;
  assign w_q_nx   = {r_q[WIDTH_IN-2:0], w_ge};

  // State register; en=0 freezes the FSM wherever it is.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
    end else if (en) begin
      r_state <= w_state_nx;
    end
  end

  // Next-state decode plus the busy/ready strobes.
  always_comb begin
    w_state_nx = r_state;
    w_accept   = 1'b0;
    w_last     = 1'b0;
    w_busy     = 1'b0;
    w_ready    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state_nx = S_CALC;
          w_accept   = 1'b1;
        end
      end
      S_CALC: begin
        w_busy = 1'b1;
        if (r_cnt == CNT_LAST) begin
          w_state_nx = S_DONE;
          w_last     = 1'b1;
        end
      end
      S_DONE: begin
        w_ready    = 1'b1;
        w_state_nx = S_IDLE;
      end
      default: w_state_nx = S_IDLE;
    endcase
  end

  // Iteration counter, cleared on each accepted start.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt <= '0;
    end else if (en) begin
      if (w_accept) begin
        r_cnt <= '0;
      end else if (r_state == S_CALC) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

  // Operand latch and quotient/remainder shift registers.
  always_ff @(posedge clk) begin
    if (en) begin
      if (w_accept) begin
        r_q    <= dividend;
        r_dreg <= divisor;
        r_rem  <= '0;
      end else if (r_state == S_CALC) begin
        r_q   <= w_q_nx;
        r_rem <= w_rem_nx;
      end
    end
  end

  // Capture the saturated result and flags as the last step completes.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_result   <= '0;
      r_overflow <= 1'b0;
      r_div_zero <= 1'b0;
    end else if (en && w_last) begin
      r_result   <= sat_quot(w_q_nx);
      r_overflow <= quot_ovf(w_q_nx);
      r_div_zero <= (r_dreg == '0);
    end
  end

  assign busy     = w_busy;
  assign ready    = w_ready;
  assign result   = r_result;
  assign overflow = r_overflow;
  assign div_zero = r_div_zero;

endmodule

// File: tb/tb_seq_divider.sv
// Directed and randomised bench for seq_divider.
module tb_seq_divider;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        en = 1'b1;
  logic        start = 1'b0;
  logic [25:0] dividend = '0;
  logic [25:0] divisor = '0;
  logic        busy;
  logic        ready;
  logic [15:0] result;
  logic        overflow;
  logic        div_zero;

  int n_err = 0;
  int n_chk = 0;
  int cyc = 0;
  int t0 = 0;
  bit both_hi = 1'b0;

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  seq_divider dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .start    (start),
    .dividend (dividend),
    .divisor  (divisor),
    .busy     (busy),
    .ready    (ready),
    .result   (result),
    .overflow (overflow),
    .div_zero (div_zero)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: saturated quotient with {result, overflow, div_zero}.
  function automatic logic [17:0] model(input logic [25:0] a, input logic [25:0] b);
    logic [25:0] q;
    if (b == 26'd0) return {16'hFFFF, 1'b1, 1'b1};
    q = a / b;
    if (q > 26'd65535) return {16'hFFFF, 1'b1, 1'b0};
    return {q[15:0], 1'b0, 1'b0};
  endfunction

  task automatic launch(input logic [25:0] a, input logic [25:0] b);
    @(negedge clk);
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    t0       = cyc;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_ready(output int lat);
    bit seen;
    seen = 1'b0;
    lat  = -1;
    for (int k = 0; k < 200 && !seen; k++) begin
      if (busy && ready) both_hi = 1'b1;
      if (ready) begin
        seen = 1'b1;
        lat  = cyc - t0;
      end else begin
        @(negedge clk);
      end
    end
  endtask

  task automatic run_op(input string tag, input logic [25:0] a, input logic [25:0] b,
                        input logic [15:0] er, input logic eo, input logic ez);
    int lat;
    launch(a, b);
    wait_ready(lat);
    check({tag, "_lat"}, lat, 27);
    check({tag, "_res"}, {16'd0, result}, {16'd0, er});
    check({tag, "_ovf"}, {31'd0, overflow}, {31'd0, eo});
    check({tag, "_dz"}, {31'd0, div_zero}, {31'd0, ez});
    @(negedge clk);
    check({tag, "_pulse"}, {31'd0, ready}, 32'd0);
    check({tag, "_hold"}, {16'd0, result}, {16'd0, er});
  endtask

  initial begin
    int lat;
    int tprev;
    int period_bad;
    bit seen;
    logic [25:0] ra;
    logic [25:0] rb;
    logic [17:0] exp_pk;

    // Reset state
    #3;
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_ready", {31'd0, ready}, 32'd0);
    check("rst_result", {16'd0, result}, 32'd0);
    check("rst_flags", {30'd0, overflow, div_zero}, 32'd0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (5) @(negedge clk);
    check("idle_busy", {31'd0, busy}, 32'd0);
    check("idle_ready", {31'd0, ready}, 32'd0);
    check("idle_result", {16'd0, result}, 32'd0);

    // Directed operations
    run_op("basic", 26'd1000000, 26'd2750, 16'd363, 1'b0, 1'b0);
    run_op("sat", 26'h3FFFFFF, 26'd1, 16'hFFFF, 1'b1, 1'b0);
    run_op("max", 26'd65535, 26'd1, 16'd65535, 1'b0, 1'b0);
    run_op("dz", 26'd12345, 26'd0, 16'hFFFF, 1'b1, 1'b1);
    run_op("small", 26'd100, 26'd7, 16'd14, 1'b0, 1'b0);

    // Start re-pulsed mid-operation with new operands
    launch(26'd100, 26'd7);
    repeat (4) @(negedge clk);
    dividend = 26'd5000;
    divisor  = 26'd3;
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_ready(lat);
    check("repulse_lat", lat, 27);
    check("repulse_res", {16'd0, result}, 32'd14);
    @(negedge clk);

    // Clock-enable freeze mid-operation
    launch(26'd1000000, 26'd2750);
    repeat (9) @(negedge clk);
    en = 1'b0;
    repeat (5) @(negedge clk);
    check("freeze_busy", {31'd0, busy}, 32'd1);
    en = 1'b1;
    wait_ready(lat);
    check("freeze_lat", lat, 32);
    check("freeze_res", {16'd0, result}, 32'd363);
    en = 1'b0;
    @(negedge clk);
    check("freeze_done_ready", {31'd0, ready}, 32'd1);
    en = 1'b1;
    @(negedge clk);
    check("unfreeze_ready", {31'd0, ready}, 32'd0);

    // Asynchronous reset mid-operation
    launch(26'd1000000, 26'd2750);
    repeat (10) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    check("arst_busy", {31'd0, busy}, 32'd0);
    check("arst_result", {16'd0, result}, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (ready || busy) seen = 1'b1;
    end
    check("arst_no_ready", {31'd0, seen}, 32'd0);

    // Random operands with start held high
    period_bad = 0;
    ra = 26'($urandom);
    rb = 26'($urandom) >> $urandom_range(0, 25);
    exp_pk = model(ra, rb);
    @(negedge clk);
    dividend = ra;
    divisor  = rb;
    start    = 1'b1;
    t0       = cyc;
    tprev    = 0;
    @(negedge clk);
    for (int i = 0; i < 1000; i++) begin
      wait_ready(lat);
      if (i == 0) begin
        check("rand_first_lat", lat, 27);
      end else if (cyc - tprev != 28) begin
        period_bad++;
      end
      tprev = cyc;
      check("rand", {14'd0, result, overflow, div_zero}, {14'd0, exp_pk});
      ra = 26'($urandom);
      if ($urandom_range(0, 31) == 0) rb = 26'd0;
      else rb = 26'($urandom) >> $urandom_range(0, 25);
      exp_pk   = model(ra, rb);
      dividend = ra;
      divisor  = rb;
      @(negedge clk);
    end
    start = 1'b0;
    check("rand_period", period_bad, 0);
    check("busy_ready_excl", {31'd0, both_hi}, 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
